// File: rtl/sar_search.sv
// sar_search: successive-approximation search controller.
// Drives the trial operand of an external comparator (target on its a-side,
// trial on its b-side) and uses the greater/less flags to recover the target
// one bit per clock, MSB first. Supports unsigned and two's-complement searches.
// The search runs over an offset-binary code; in signed mode the MSB of the
// code is flipped to form the trial.
// Optional build macro: SAR_EARLY_EXIT_EN. When defined, an equal compare ends
// the search at once. Undefined, every search takes WIDTH TRY cycles.
//
// state  | meaning
// S_IDLE | waiting for i_start; outputs hold last result
// S_TRY  | one comparator decision per cycle, bit r_i of r_c under test
// S_DONE | one-cycle o_done pulse, result/exact valid
module sar_search #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_tc,
    input  logic             i_cmp_g,
    input  logic             i_cmp_l,
    output logic [WIDTH-1:0] o_trial,
    output logic             o_tc_out,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result,
    output logic             o_exact,
    output logic             o_err
);

    localparam int IW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_TRY,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_c;
    logic [IW-1:0]    r_i;
    logic             r_tc;
    logic             r_exact_acc;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_result;
    logic             r_exact;
    logic             r_err;

    logic [WIDTH-1:0] w_flip;
    logic [WIDTH-1:0] w_mask;
    logic [WIDTH-1:0] w_c_next;
    logic             w_less;
    logic             w_eq;
    logic             w_both;
    logic             w_early;

    // Both flags high is a comparator fault; it falls into the "less" branch
    // because cmp_l alone decides whether the bit under test is cleared.
    assign w_less = i_cmp_l;
    assign w_eq   = ~i_cmp_g & ~i_cmp_l;
    assign w_both = i_cmp_g & i_cmp_l;

`ifdef SAR_EARLY_EXIT_EN
    assign w_early = w_eq;
`else
    assign w_early = 1'b0;
`endif

    assign o_trial  = r_c ^ w_flip;
    assign o_tc_out = r_tc;
    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_result = r_result;
    assign o_exact  = r_exact;
    assign o_err    = r_err;

    // Next offset code: resolve the bit under test, then seed the next bit.
    always_comb begin
        w_flip            = '0;
        w_flip[WIDTH-1]   = r_tc;
        w_mask            = {{(WIDTH-1){1'b0}}, 1'b1} << r_i;
        w_c_next          = r_c;
        if (w_less) begin
            w_c_next = r_c & ~w_mask;
        end
        if (r_i != '0) begin
            w_c_next = w_c_next | (w_mask >> 1);
        end
    end

    // Search FSM with registered status outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_c         <= '0;
            r_i         <= '0;
            r_tc        <= 1'b0;
            r_exact_acc <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_result    <= '0;
            r_exact     <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_tc        <= i_tc;
                        r_c         <= {1'b1, {(WIDTH-1){1'b0}}};
                        r_i         <= IW'(WIDTH-1);
                        r_exact_acc <= 1'b0;
                        r_exact     <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= S_TRY;
                    end
                end
                S_TRY: begin
                    if (w_both) begin
                        r_err <= 1'b1;
                    end
                    if (w_early) begin
                        r_result <= o_trial;
                        r_exact  <= 1'b1;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_c <= w_c_next;
                        r_i <= r_i - 1'b1;
                        if (w_eq) begin
                            r_exact_acc <= 1'b1;
                        end
                        if (r_i == '0) begin
                            r_result <= w_c_next ^ w_flip;
                            r_exact  <= r_exact_acc | w_eq;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sar_search.sv
// Testbench for sar_search (WIDTH = 4) with a behavioural comparator and a
// binary-search reference model for the expected trial sequence.
module tb_sar_search;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         tc;
    logic         cmp_g;
    logic         cmp_l;
    logic [W-1:0] trial;
    logic         tc_out;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         exact;
    logic         err;

    logic [W-1:0] target;
    logic         force_both;
    logic         exp_err;
    int           checks;
    int           failures;

    always #5 clk = ~clk;

    sar_search #(.WIDTH(W)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_start  (start),
        .i_tc     (tc),
        .i_cmp_g  (cmp_g),
        .i_cmp_l  (cmp_l),
        .o_trial  (trial),
        .o_tc_out (tc_out),
        .o_busy   (busy),
        .o_done   (done),
        .o_result (result),
        .o_exact  (exact),
        .o_err    (err)
    );

    // External magnitude comparator: a = target, b = trial.
    always_comb begin
        cmp_g = 1'b0;
        cmp_l = 1'b0;
        if (force_both) begin
            cmp_g = 1'b1;
            cmp_l = 1'b1;
        end else if (tc_out) begin
            cmp_g = $signed(target) > $signed(trial);
            cmp_l = $signed(target) < $signed(trial);
        end else begin
            cmp_g = target > trial;
            cmp_l = target < trial;
        end
    end

    // Trial k of a binary search: the top k bits of the target's offset code,
    // then a 1, then zeros; mapped back to the operand domain.
    function automatic logic [W-1:0] model_trial(input logic [W-1:0] tgt, input logic m, input int k);
        int flip;
        int u;
        int t;
        flip = m ? (1 << (W-1)) : 0;
        u = int'(tgt) ^ flip;
        t = ((u >> (W-k)) << (W-k)) | (1 << (W-1-k));
        return W'(t ^ flip);
    endfunction

    // One search starting at a negedge in IDLE; returns at the negedge of the
    // IDLE cycle after DONE so the next call lands back-to-back.
    task automatic run_search(input logic [W-1:0] tgt, input logic m);
        logic [W-1:0] exp_t [W];
        int           n;
        bit           exp_ex;
        logic [W-1:0] held;
        n = W;
        exp_ex = 1'b0;
        for (int k = 0; k < W; k++) begin
            exp_t[k] = model_trial(tgt, m, k);
            if (exp_t[k] == tgt && !exp_ex) begin
                exp_ex = 1'b1;
`ifdef SAR_EARLY_EXIT_EN
                n = k + 1;
`endif
            end
        end
        target = tgt;
        tc = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < n; k++) begin
            checks++;
            if (trial !== exp_t[k]) begin
                failures++;
                $display("FAIL trial tgt=%b m=%0d k=%0d got=%b exp=%b", tgt, m, k, trial, exp_t[k]);
            end
            checks++;
            if ({busy, done} !== 2'b10) begin
                failures++;
                $display("FAIL try_flags tgt=%b k=%0d busy,done got=%b exp=10", tgt, k, {busy, done});
            end
            start = 1'($urandom_range(0, 1));
            tc = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        checks++;
        if ({busy, done} !== 2'b11) begin
            failures++;
            $display("FAIL done_flags tgt=%b m=%0d busy,done got=%b exp=11", tgt, m, {busy, done});
        end
        checks++;
        if (result !== tgt) begin
            failures++;
            $display("FAIL result tgt=%b m=%0d got=%b exp=%b", tgt, m, result, tgt);
        end
        checks++;
        if (exact !== exp_ex) begin
            failures++;
            $display("FAIL exact tgt=%b m=%0d got=%b exp=%b", tgt, m, exact, exp_ex);
        end
        checks++;
        if (tc_out !== m) begin
            failures++;
            $display("FAIL tc_out tgt=%b got=%b exp=%b", tgt, tc_out, m);
        end
        checks++;
        if (err !== exp_err) begin
            failures++;
            $display("FAIL err tgt=%b m=%0d got=%b exp=%b", tgt, m, err, exp_err);
        end
        held = tgt;
        start = 1'($urandom_range(0, 1));
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({busy, done, result} !== {2'b00, held}) begin
            failures++;
            $display("FAIL idle_after tgt=%b busy,done,result got=%b exp=%b", tgt, {busy, done, result}, {2'b00, held});
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({trial, tc_out, busy, done, result, exact, err} !== '0) begin
            failures++;
            $display("FAIL reset_state got=%b exp=0", {trial, tc_out, busy, done, result, exact, err});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        run_search(4'b0101, 1'b0);
        run_search(4'b1101, 1'b1);
        run_search(4'b1000, 1'b0);
    endtask

    task automatic test_sweep();
        for (int m = 0; m < 2; m++) begin
            for (int v = 0; v < (1 << W); v++) begin
                run_search(W'(v), 1'(m));
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            run_search(W'($urandom_range(0, (1 << W) - 1)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic test_err();
        int cnt;
        target = 4'b0110;
        tc = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        force_both = 1'b1;
        @(negedge clk);
        force_both = 1'b0;
        cnt = 0;
        while (!done && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL err_search_done got=%b exp=1 after %0d cycles", done, cnt);
        end
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL err_set got=%b exp=1", err);
        end
        @(negedge clk);
        exp_err = 1'b1;
        run_search(4'b0011, 1'b0);
        run_search(4'b1110, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_err = 1'b0;
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL err_clear got=%b exp=0", err);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int pulses;
        target = 4'b0011;
        tc = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({trial, tc_out, busy, done, result, exact, err} !== '0) begin
            failures++;
            $display("FAIL reset_mid_state got=%b exp=0", {trial, tc_out, busy, done, result, exact, err});
        end
        rst_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL reset_mid_no_done got=%0d active cycles exp=0", pulses);
        end
        run_search(4'b1011, 1'b0);
        run_search(4'b0011, 1'b1);
    endtask

    task automatic test_back_to_back();
        run_search(4'b0000, 1'b0);
        run_search(4'b1111, 1'b0);
        run_search(4'b1000, 1'b1);
        run_search(4'b0111, 1'b1);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        start = 1'b0;
        tc = 1'b0;
        target = '0;
        force_both = 1'b0;
        exp_err = 1'b0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_sweep();
        test_random();
        test_back_to_back();
        test_err();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sar_search.md
# sar_search

Successive-approximation search controller that drives the trial operand of an external magnitude comparator and consumes its greater/less flags to recover an unknown target value, one bit per clock, MSB first. It sits on the opposite side of the comparator interface: the comparator's `a` input carries the target, `b` carries this block's `trial`, and the comparator's final-stage greater/less outputs return here. The block supports unsigned and two's-complement searches, mirroring the comparator's `tc` mode.

## Interface

- `WIDTH`, default 4, operand width in bits; legal range 2 to 16.

- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  synchronous, active-low reset.
- `start`  input  1  request a search; sampled only in IDLE.
- `tc`  input  1  mode: 0 = unsigned, 1 = two's complement; sampled with `start`.
- `cmp_g`  input  1  comparator says target > trial (combinational from `trial`).
- `cmp_l`  input  1  comparator says target < trial.
- `trial`  output  WIDTH  operand driven to the comparator's `b` input.
- `tc_out`  output  1  registered mode, wired to the comparator's `tc` input.
- `busy`  output  1  high in TRY and DONE.
- `done`  output  1  one-cycle pulse; `result` is valid from this cycle on.
- `result`  output  WIDTH  recovered target; held until the next accepted `start`.
- `exact`  output  1  an equal compare was seen during the last search.
- `err`  output  1  sticky; `cmp_g` and `cmp_l` were both high in a TRY cycle.

## Operation

- Internal offset-binary code `c` (WIDTH bits), bit index `i`, and registered `tc_r`.
- `trial = c ^ (tc_r << (WIDTH-1))`: the MSB is flipped in signed mode, so the search runs over the offset code.
- States:
  - IDLE: `busy` = 0. On `start`, latch `tc_r = tc`, set `c = 1 << (WIDTH-1)`, set `i = WIDTH-1`, clear `exact`, go to TRY. `start` with `rst_n` low is ignored.
  - TRY: sample `cmp_g`/`cmp_l` against the current `trial`.
    - `cmp_l` = 1: clear bit `i` of `c`.
    - Otherwise: keep bit `i`.
    - Neither flag high (equal): set `exact`.
    - Both flags high: set `err` and treat the compare as less.
    - If `i` > 0: set bit `i-1` of `c`, decrement `i`, stay in TRY.
    - If `i` = 0: load `result` with the final trial value and go to DONE.
  - DONE: `done` = 1 for exactly one cycle, then return to IDLE.
- `start` is ignored in TRY and DONE; there is no queuing.
- `err` clears only on reset. All other state and outputs clear on reset.
- Comparator inputs are assumed valid in the same cycle `trial` changes. The comparator path is purely combinational.

## Timing

- Reset values: `trial` = 0, `tc_out` = 0, `busy` = 0, `done` = 0, `result` = 0, `exact` = 0, `err` = 0, state IDLE.
- `start` sampled at edge t:
  - First TRY cycle is t+1, with trial = 1000… (unsigned) or 0000… (signed).
  - `done` is high in cycle t+WIDTH+1.
  - `busy` is high in cycles t+1 through t+WIDTH+1.
  - The next `start` is accepted at the edge ending cycle t+WIDTH+2, giving back-to-back throughput of one search per WIDTH+2 cycles.
- `result` and `exact` update on the edge entering DONE and are stable while `done` is high.
- Reset asserted in any state: the next cycle is IDLE with all outputs at their reset values. A search in progress is abandoned and no `done` is produced.

## Configuration

- `SAR_EARLY_EXIT_EN`
  - Defined: an equal compare in TRY loads `result = trial`, sets `exact`, and goes to DONE immediately, regardless of `i`. `done` can arrive as early as t+2.
  - Undefined: every search takes the full WIDTH TRY cycles; equality only sets `exact`.
  - `result` is identical in both builds for the same target.

## Test plan

- Unsigned, WIDTH = 4, target 0101: trials 1000, 0100, 0110, 0101 → `result` = 0101, `exact` = 1, `done` at t+5.
- Signed, target 1101 (−3): trials 0000, 1100, 1110, 1101 → `result` = 1101, `tc_out` = 1, `done` at t+5.
- Target 1000 unsigned:
  - Without the macro: trials 1000, 1100, 1010, 1001 → `result` = 1000, `done` at t+5.
  - With `SAR_EARLY_EXIT_EN`: `done` at t+2 with `result` = 1000.
- Exhaustive sweep of all 16 targets in both modes against a comparator model → `result` equals target every time, `err` = 0, `start` pulses while `busy` are ignored.
- Force `cmp_g` = `cmp_l` = 1 in the second TRY cycle → `err` goes high and stays high through later searches until `rst_n` = 0.
- Drop `rst_n` in the third TRY cycle → the next cycle is IDLE with all outputs 0, no `done` pulse, and a new `start` works normally.
